// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Shared front-end types. Holds the return-address-stack default geometry and
// the checkpoint record the RAS exports with every prediction and accepts back
// from the backend on a misprediction.
//
// Optional feature macro: RAS_CHECKPOINT_TOP_EN
//   defined   -> ras_checkpoint_t also carries top_value (the entry at tos)
//   undefined -> ras_checkpoint_t is pointer and count only
// ---------------------------------------------------------------------------
package riscv_pkg;

    localparam int RAS_DEPTH = 8;
    localparam int RAS_XLEN  = 32;
    localparam int RAS_PTR_W = $clog2(RAS_DEPTH);

    typedef struct packed {
`ifdef RAS_CHECKPOINT_TOP_EN
        logic [RAS_XLEN-1:0]  top_value;
`endif
        logic [RAS_PTR_W:0]   count;
        logic [RAS_PTR_W-1:0] tos;
    } ras_checkpoint_t;

endpackage

// File: rtl/return_address_stack.sv
// ---------------------------------------------------------------------------
// return_address_stack
// Circular return address stack in the IF stage. Pushes the link address on
// calls, pops on returns, swaps the top on coroutine jumps, and predicts the
// return target combinationally from the registered top of stack. Every cycle
// it exports a checkpoint of its pre-update state so the backend can undo
// wrong-path pushes and pops.
//
// Optional feature macro: RAS_CHECKPOINT_TOP_EN (also repair the top entry on
// restore from the checkpointed top_value).
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_stall               IF stalled; blocks every update except restore
//   i_is_call             push i_link_addr
//   i_is_return           pop
//   i_is_coroutine        overwrite the top with i_link_addr (pop then push)
//   i_link_addr           return address to push
//   o_pred_valid          o_pred_target is usable this cycle
//   o_pred_target         predicted return target
//   o_ckpt                snapshot of the current registered state
//   i_restore_valid       load state from i_restore_ckpt
//   i_restore_ckpt        snapshot to restore
// ---------------------------------------------------------------------------
module return_address_stack
    import riscv_pkg::*;
#(
    parameter int DEPTH = RAS_DEPTH,
    parameter int XLEN  = RAS_XLEN
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_stall,
    input  logic            i_is_call,
    input  logic            i_is_return,
    input  logic            i_is_coroutine,
    input  logic [XLEN-1:0] i_link_addr,
    output logic            o_pred_valid,
    output logic [XLEN-1:0] o_pred_target,
    output ras_checkpoint_t o_ckpt,
    input  logic            i_restore_valid,
    input  ras_checkpoint_t i_restore_ckpt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] ONE_COUNT  = (PTR_W+1)'(1);

    // The checkpoint type is sized from the package, so the instance geometry
    // has to agree with it.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || DEPTH != RAS_DEPTH || XLEN != RAS_XLEN)
    begin : g_bad_cfg
        $error("return_address_stack: DEPTH/XLEN must be a power of two >= 2 matching riscv_pkg");
    end

    logic [XLEN-1:0]  entries [DEPTH];
    logic [PTR_W-1:0] tos_q, tos_d;
    logic [PTR_W:0]   count_q, count_d;

    logic             wr_en;
    logic [PTR_W-1:0] wr_idx;
    logic [XLEN-1:0]  wr_data;

    logic             nonempty;
    logic             pop_req;

    assign nonempty = (count_q != '0);
    assign pop_req  = i_is_return | i_is_coroutine;

    // Prediction: zero latency, straight from the registered top of stack.
    assign o_pred_valid  = pop_req & nonempty;
    assign o_pred_target = o_pred_valid ? entries[tos_q] : '0;

    always_comb begin
        o_ckpt       = '0;
        o_ckpt.tos   = tos_q;
        o_ckpt.count = count_q;
`ifdef RAS_CHECKPOINT_TOP_EN
        o_ckpt.top_value = entries[tos_q];
`endif
    end

    // Next-state and single array write port, in priority order:
    // restore, stall, coroutine, call, return.
    // NOTE: every signal gets a default at the top of always_comb so no path
    // can leave it unassigned and infer a latch.
    always_comb begin
        tos_d   = tos_q;
        count_d = count_q;
        wr_en   = 1'b0;
        wr_idx  = tos_q;
        wr_data = i_link_addr;

        if (i_restore_valid) begin
            // Repair happens even while IF is stalled; concurrent ops are dropped.
            tos_d   = i_restore_ckpt.tos;
            count_d = i_restore_ckpt.count;
`ifdef RAS_CHECKPOINT_TOP_EN
            wr_en   = 1'b1;
            wr_idx  = i_restore_ckpt.tos;
            wr_data = i_restore_ckpt.top_value;
`endif
        end else if (!i_stall) begin
            if (i_is_coroutine) begin
                // Pop-then-push collapses to an in-place overwrite of the top.
                wr_en  = 1'b1;
                wr_idx = tos_q;
                if (!nonempty) begin
                    count_d = ONE_COUNT;
                end
            end else if (i_is_call) begin
                // Call wins over a simultaneous return. When full the pointer
                // wraps onto the oldest entry and the count saturates.
                tos_d   = tos_q + 1'b1;
                wr_en   = 1'b1;
                wr_idx  = tos_q + 1'b1;
                count_d = (count_q == FULL_COUNT) ? count_q : count_q + 1'b1;
            end else if (i_is_return && nonempty) begin
                tos_d   = tos_q - 1'b1;
                count_d = count_q - 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tos_q   <= '0;
            count_q <= '0;
        end else begin
            tos_q   <= tos_d;
            count_q <= count_d;
        end
    end

    // NOTE: the entry array has no reset; count==0 already marks every entry
    // as invalid, and leaving it unreset lets it map onto plain RAM/flops.
    always_ff @(posedge i_clk) begin
        if (!i_rst && wr_en) begin
            entries[wr_idx] <= wr_data;
        end
    end

endmodule

// File: tb/tb_return_address_stack.sv
// ---------------------------------------------------------------------------
// tb_return_address_stack
// Self-checking bench: table-driven directed vectors, hand-written restore and
// stall sequences, then randomized traffic against a reference model.
// ---------------------------------------------------------------------------
module tb_return_address_stack;
    import riscv_pkg::*;

    localparam int DEPTH = 8;
    localparam int XLEN  = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            stall;
    logic            is_call;
    logic            is_return;
    logic            is_cor;
    logic [XLEN-1:0] link_addr;
    logic            pred_valid;
    logic [XLEN-1:0] pred_target;
    ras_checkpoint_t ckpt;
    logic            restore_valid;
    ras_checkpoint_t restore_ckpt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    return_address_stack #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_stall        (stall),
        .i_is_call      (is_call),
        .i_is_return    (is_return),
        .i_is_coroutine (is_cor),
        .i_link_addr    (link_addr),
        .o_pred_valid   (pred_valid),
        .o_pred_target  (pred_target),
        .o_ckpt         (ckpt),
        .i_restore_valid(restore_valid),
        .i_restore_ckpt (restore_ckpt)
    );

    typedef struct {
        logic            call;
        logic            ret;
        logic            cor;
        logic            stl;
        logic [XLEN-1:0] link;
        logic            exp_valid;
        logic [XLEN-1:0] exp_target;
        int              exp_count;   // count after the edge
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    function automatic vec_t mk(input logic c, input logic r, input logic o, input logic s,
                                input logic [XLEN-1:0] l, input logic ev,
                                input logic [XLEN-1:0] et, input int ec);
        vec_t v;
        v.call = c; v.ret = r; v.cor = o; v.stl = s; v.link = l;
        v.exp_valid = ev; v.exp_target = et; v.exp_count = ec;
        return v;
    endfunction

    task automatic idle();
        is_call       = 1'b0;
        is_return     = 1'b0;
        is_cor        = 1'b0;
        stall         = 1'b0;
        restore_valid = 1'b0;
        link_addr     = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Drive one vector, check the combinational prediction, clock it in and
    // check the resulting count.
    task automatic apply_vec(input vec_t v, input string name);
        is_call   = v.call;
        is_return = v.ret;
        is_cor    = v.cor;
        stall     = v.stl;
        link_addr = v.link;
        #1;
        check({name, " valid"}, 64'(pred_valid), 64'(v.exp_valid));
        check({name, " target"}, 64'(pred_target), 64'(v.exp_target));
        tick();
        check({name, " count"}, 64'(ckpt.count), 64'(v.exp_count));
        idle();
    endtask

    task automatic run_table(input string name);
        foreach (vecs[i]) apply_vec(vecs[i], $sformatf("%s[%0d]", name, i));
        vecs.delete();
    endtask

    task automatic do_restore(input ras_checkpoint_t ck, input logic stall_v, input logic call_v);
        idle();
        restore_valid = 1'b1;
        restore_ckpt  = ck;
        stall         = stall_v;
        is_call       = call_v;   // must be ignored
        link_addr     = 32'hDEAD;
        tick();
        idle();
    endtask

    // ---------------- reference model ----------------
    logic [XLEN-1:0] m_mem [DEPTH];
    int m_tos;
    int m_count;

    typedef struct {
        int              tos;
        int              count;
        logic [XLEN-1:0] top;
    } snap_t;

    snap_t           m_hist[$];
    ras_checkpoint_t d_hist[$];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        ras_checkpoint_t ck;
        restore_ckpt = '0;
        do_reset();

        // Reset state, then return on empty stack.
        check("reset tos", 64'(ckpt.tos), 64'd0);
        check("reset count", 64'(ckpt.count), 64'd0);
        vecs.push_back(mk(0, 1, 0, 0, 32'h0, 0, 32'h0, 0));
        run_table("empty_ret");
        check("empty_ret tos", 64'(ckpt.tos), 64'd0);

        // Three pushes, four pops.
        vecs.push_back(mk(1, 0, 0, 0, 32'h100, 0, 32'h0, 1));
        vecs.push_back(mk(1, 0, 0, 0, 32'h200, 0, 32'h0, 2));
        vecs.push_back(mk(1, 0, 0, 0, 32'h300, 0, 32'h0, 3));
        vecs.push_back(mk(0, 1, 0, 0, 32'h0, 1, 32'h300, 2));
        vecs.push_back(mk(0, 1, 0, 0, 32'h0, 1, 32'h200, 1));
        vecs.push_back(mk(0, 1, 0, 0, 32'h0, 1, 32'h100, 0));
        vecs.push_back(mk(0, 1, 0, 0, 32'h0, 0, 32'h0, 0));
        run_table("lifo");

        // Overflow: nine pushes saturate at DEPTH, oldest entry lost.
        for (int i = 1; i <= 9; i++)
            vecs.push_back(mk(1, 0, 0, 0, 32'(i * 16), 0, 32'h0, (i < DEPTH) ? i : DEPTH));
        for (int i = 9; i >= 2; i--)
            vecs.push_back(mk(0, 1, 0, 0, 32'h0, 1, 32'(i * 16), i - 2));
        vecs.push_back(mk(0, 1, 0, 0, 32'h0, 0, 32'h0, 0));
        // Call and return together behaves as a call.
        vecs.push_back(mk(1, 1, 0, 0, 32'hA0, 0, 32'h0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 32'h0, 1, 32'hA0, 0));
        run_table("wrap");

        // Coroutine swaps the top; coroutine on empty stack pushes.
        vecs.push_back(mk(1, 0, 0, 0, 32'h400, 0, 32'h0, 1));
        vecs.push_back(mk(1, 1, 1, 0, 32'h500, 1, 32'h400, 1));
        vecs.push_back(mk(0, 1, 0, 0, 32'h0, 1, 32'h500, 0));
        vecs.push_back(mk(0, 0, 1, 0, 32'h550, 0, 32'h0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 32'h0, 1, 32'h550, 0));
        run_table("coroutine");

        // Restore after wrong-path push/pop/pop.
        do_reset();
        apply_vec(mk(1, 0, 0, 0, 32'h1000, 0, 32'h0, 1), "ckA push");
        ck = ckpt;
        apply_vec(mk(1, 0, 0, 0, 32'h2000, 0, 32'h0, 2), "ckA push2");
        apply_vec(mk(0, 1, 0, 0, 32'h0, 1, 32'h2000, 1), "ckA pop1");
        apply_vec(mk(0, 1, 0, 0, 32'h0, 1, 32'h1000, 0), "ckA pop2");
        do_restore(ck, 1'b0, 1'b1);
        check("ckA restored count", 64'(ckpt.count), 64'd1);
        apply_vec(mk(0, 1, 0, 0, 32'h0, 1, 32'h1000, 0), "ckA ret");

        // Restore after speculative pop then push over the live entry.
        do_reset();
        apply_vec(mk(1, 0, 0, 0, 32'h1000, 0, 32'h0, 1), "ckB push");
        ck = ckpt;
        apply_vec(mk(0, 1, 0, 0, 32'h0, 1, 32'h1000, 0), "ckB pop");
        apply_vec(mk(1, 0, 0, 0, 32'h3000, 0, 32'h0, 1), "ckB push2");
        do_restore(ck, 1'b0, 1'b0);
`ifdef RAS_CHECKPOINT_TOP_EN
        apply_vec(mk(0, 1, 0, 0, 32'h0, 1, 32'h1000, 0), "ckB ret");
`else
        apply_vec(mk(0, 1, 0, 0, 32'h0, 1, 32'h3000, 0), "ckB ret");
`endif

        // Stall blocks updates but not restore.
        do_reset();
        apply_vec(mk(1, 0, 0, 0, 32'h600, 0, 32'h0, 1), "stall push");
        ck = ckpt;
        apply_vec(mk(1, 0, 0, 1, 32'h700, 0, 32'h0, 1), "stall call");
        check("stall tos", 64'(ckpt.tos), 64'(ck.tos));
        apply_vec(mk(0, 1, 0, 1, 32'h0, 1, 32'h600, 1), "stall ret");
        apply_vec(mk(1, 0, 0, 0, 32'h650, 0, 32'h0, 2), "stall push2");
        do_restore(ck, 1'b1, 1'b0);
        check("stall restore count", 64'(ckpt.count), 64'd1);
        check("stall restore tos", 64'(ckpt.tos), 64'(ck.tos));
        apply_vec(mk(0, 1, 0, 0, 32'h0, 1, 32'h600, 0), "stall final ret");

        // Randomized traffic against the model.
        do_reset();
        m_tos = 0;
        m_count = 0;
        foreach (m_mem[i]) m_mem[i] = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int op;
            logic ev;
            logic [XLEN-1:0] et;
            snap_t s;

            // Remember the current state from both sides for later restores.
            s.tos = m_tos; s.count = m_count; s.top = m_mem[m_tos];
            m_hist.push_back(s);
            d_hist.push_back(ckpt);
            if (m_hist.size() > 16) begin
                void'(m_hist.pop_front());
                void'(d_hist.pop_front());
            end

            idle();
            op = $urandom_range(0, 99);
            link_addr = $urandom;
            stall = ($urandom_range(0, 7) == 0);
            if (op < 40) is_call = 1'b1;
            else if (op < 80) is_return = 1'b1;
            else if (op < 88) begin
                is_cor = 1'b1;
                is_call = 1'(($urandom_range(0, 1)));
                is_return = 1'(($urandom_range(0, 1)));
            end else if (op < 92) begin
                is_call = 1'b1;
                is_return = 1'b1;
            end else if (op < 97) begin
                int idx;
                idx = $urandom_range(0, m_hist.size() - 1);
                restore_valid = 1'b1;
                restore_ckpt = d_hist[idx];
                s = m_hist[idx];
            end
            #1;
            ev = (is_return | is_cor) && (m_count != 0);
            et = ev ? m_mem[m_tos] : '0;
            check($sformatf("rnd%0d valid", cyc), 64'(pred_valid), 64'(ev));
            check($sformatf("rnd%0d target", cyc), 64'(pred_target), 64'(et));
            check($sformatf("rnd%0d tos", cyc), 64'(ckpt.tos), 64'(m_tos));
            check($sformatf("rnd%0d count", cyc), 64'(ckpt.count), 64'(m_count));
`ifdef RAS_CHECKPOINT_TOP_EN
            if (m_count != 0)
                check($sformatf("rnd%0d top", cyc), 64'(ckpt.top_value), 64'(m_mem[m_tos]));
`endif
            // Model update from the stack rules.
            if (restore_valid) begin
                m_tos = s.tos;
                m_count = s.count;
`ifdef RAS_CHECKPOINT_TOP_EN
                m_mem[m_tos] = s.top;
`endif
            end else if (!stall) begin
                if (is_cor) begin
                    m_mem[m_tos] = link_addr;
                    if (m_count == 0) m_count = 1;
                end else if (is_call) begin
                    m_tos = (m_tos + 1) % DEPTH;
                    m_mem[m_tos] = link_addr;
                    if (m_count < DEPTH) m_count++;
                end else if (is_return && m_count > 0) begin
                    m_tos = (m_tos + DEPTH - 1) % DEPTH;
                    m_count--;
                end
            end
            tick();
        end
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
